// File: rtl/aes_pkg.sv
// Shared AES-128 inverse key-schedule types and helpers.
// Holds the FSM encoding, the last-round Rcon and word/byte utilities.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [7:0] RCON_LAST = 8'h36;
  localparam logic [3:0] ROUND_LAST = 4'd10;

  // Division by x in GF(2^8): steps Rcon backwards one round.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] y;
    if (x[0]) y = ((x ^ 8'h1B) >> 1) | 8'h80;
    else      y = x >> 1;
    return y;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Table is stored byte 0 first in the MSBs.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_off;

  // (255 - byte) * 8 selects the entry from the MSB end
  assign w_off  = {~byte_i, 3'b000};
  assign byte_o = SBOX[w_off +: 8];

endmodule

// File: rtl/inv_key_expand.sv
// AES-128 inverse key expansion: walks round keys 10 down to 0.
// One key per accepted handshake, valid/ready streaming output.
module inv_key_expand
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  output logic [127:0] rk_o,
  output logic [3:0]   round_o,
  output logic         done_o
);

  state_t       r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [127:0] w_prev;
  logic         w_hs;

  assign w_w0 = r_rk[127:96];
  assign w_w1 = r_rk[95:64];
  assign w_w2 = r_rk[63:32];
  assign w_w3 = r_rk[31:0];

  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = rot_word(w_p3);

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .byte_i (w_rot[8*i +: 8]),
      .byte_o (w_sub[8*i +: 8])
    );
  end

  assign w_p0   = w_w0 ^ w_sub ^ {r_rcon, 24'h0};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};
  assign w_hs   = r_valid & rk_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_rk    <= '0;
      r_round <= '0;
      r_rcon  <= RCON_LAST;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_rk    <= key_i;
            r_round <= ROUND_LAST;
            r_rcon  <= RCON_LAST;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            if (r_round == 4'd0) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_rk    <= w_prev;
              r_round <= r_round - 4'd1;
              r_rcon  <= inv_xtime(r_rcon);
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign rk_valid_o = r_valid;
  assign rk_o       = r_rk;
  assign round_o    = r_round;
  assign done_o     = r_done;

endmodule
